rns_ct_stream_alu: RTL
======================

Name: rns_ct_stream_alu

Overview:
- Streaming element-wise modular ALU for RNS-form ciphertexts: consumes operand residues LANES at a time, applies a per-command mode (CT+CT, CT−CT, CT+PT delta, negate) to both polynomials A and B, emits reduced results.
- Parametrised successor of the single-residue CT add path in cpu; sits between regfile read port and regfile write port, sequenced by start/done.
- Adds lane parallelism, per-prime moduli, subtraction/negation, two-stage pipeline with valid/ready backpressure.

Parameters:
- W, 32, residue width in bits
- NCOEFF, 4, coefficients per polynomial
- NPRIMES, 2, RNS primes per coefficient
- LANES, 2, residues per beat; must divide NPRIMES

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe; accepted only in IDLE
- mode  in  2  0=CT_CT_ADD, 1=CT_CT_SUB, 2=CT_PT_ADD, 3=NEG; latched on start
- prime_q  in  NPRIMES*W  modulus per prime, prime p at bits [p*W +: W]
- delta  in  NPRIMES*W  plaintext delta per prime, must be < q
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_a1, in_b1, in_a2, in_b2  in  LANES*W each  operand residues, lane k at [k*W +: W], each < q
- out_valid  out  1  result beat valid
- out_ready  in  1  sink ready
- out_a, out_b  out  LANES*W each  result residues
- out_coeff  out  clog2(NCOEFF)  coefficient index of beat
- out_prime_base  out  clog2(NPRIMES)  prime of lane 0; lane k is prime_base+k
- out_last  out  1  final beat of command
- busy  out  1  high RUN..DONE
- done  out  1  one-cycle pulse after last result beat handshake

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_last, busy, done = 0; counters, out data, out indices = 0.
- FSM: IDLE --start--> RUN; RUN --last input beat accepted--> DRAIN; DRAIN --last output handshake--> DONE; DONE --> IDLE (done=1 during DONE, one cycle).
- start while not IDLE ignored; mode, prime_q sampling per beat (prime_q/delta held stable by user for whole command).
- Beats per command = NCOEFF*NPRIMES/LANES. Input counter: prime_base += LANES, wraps to 0 at NPRIMES and increments coeff.
- in_ready = (state==RUN) && !stall; stall = stage2 valid && !out_ready.
- Stage 1 (register): per lane raw sums in W+1 bits: ADD a1+a2, b1+b2; SUB a1−a2, b1−b2 with borrow flag; PT_ADD A=a1, B=b1+delta[p]; NEG A=q−a1, B=q−b1 (operand 0 yields 0, not q). in_a2/in_b2 ignored in PT_ADD/NEG.
- Stage 2 (register): add-type: if raw ≥ q subtract q; SUB: if borrow add q. Result always < q.
- Latency input handshake → out_valid: 2 cycles without stall. Full throughput 1 beat/cycle.
- Stall freezes both stages; out data/indices hold stable while out_valid && !out_ready; no beat lost or duplicated.
- out_last asserted with final beat (coeff=NCOEFF−1, prime_base=NPRIMES−LANES).
- reset asserted mid-command: immediate return to reset values; partial results discarded; next start begins at coeff 0.
- Operand ≥ q: result undefined, not checked.

Test Plan:
- CT_CT_ADD, q={97,101}, beat a1={90,100}, a2={10,5} → out_a={3,4}; 4 beats, out_last on 4th, done pulse one cycle after final handshake.
- CT_CT_SUB, a1={3,0}, a2={10,1} → out_a={90,100}; b1=b2 → out_b={0,0}.
- CT_PT_ADD, delta={5,7}, a1={42,43}, b1={95,96} → out_a={42,43}, out_b={3,2}; in_a2/in_b2 randomized without effect.
- NEG, a1={0,5}, b1={96,1} → out_a={0,96}, out_b={1,100}.
- Backpressure: out_ready low 3 cycles mid-stream → out data/indices stable, in_ready low, all 4 beats delivered in order; start during RUN ignored.
- reset low during beat 2 → all outputs zero same cycle; new ADD command completes correctly from coeff 0.

Source files
------------

// File: rtl/rns_ct_stream_alu.sv
// Streaming RNS ciphertext ALU: element-wise modular add/sub/plaintext-add/negate
// over LANES residues per beat, two-stage pipeline with valid/ready backpressure.
module rns_ct_stream_alu #(
  parameter int unsigned W        = 32,
  parameter int unsigned NCOEFF   = 4,
  parameter int unsigned NPRIMES  = 2,
  parameter int unsigned LANES    = 2,
  localparam int unsigned CW      = (NCOEFF  > 1) ? $clog2(NCOEFF)  : 1,
  localparam int unsigned PW      = (NPRIMES > 1) ? $clog2(NPRIMES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [NPRIMES*W-1:0] prime_q,
  input  logic [NPRIMES*W-1:0] delta,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a1,
  input  logic [LANES*W-1:0]   in_b1,
  input  logic [LANES*W-1:0]   in_a2,
  input  logic [LANES*W-1:0]   in_b2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_a,
  output logic [LANES*W-1:0]   out_b,
  output logic [CW-1:0]        out_coeff,
  output logic [PW-1:0]        out_prime_base,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic [1:0] {M_ADD, M_SUB, M_PT_ADD, M_NEG} mode_e;

  function automatic logic [W-1:0] residue(input logic [NPRIMES*W-1:0] v,
                                           input logic [PW-1:0] base,
                                           input int unsigned lane);
    int unsigned idx;
    idx = 32'(base) + lane;
    return v[idx*W +: W];
  endfunction

  // Stage-1 raw value in W+1 bits; for SUB bit W is the borrow.
  function automatic logic [W:0] raw_op(input mode_e m, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic [W-1:0] q,
                                        input logic [W-1:0] d, input logic is_b);
    logic [W:0] r;
    unique case (m)
      M_ADD:    r = {1'b0, x} + {1'b0, y};
      M_SUB:    r = {1'b0, x} - {1'b0, y};
      M_PT_ADD: r = is_b ? ({1'b0, x} + {1'b0, d}) : {1'b0, x};
      default:  r = (x == '0) ? '0 : ({1'b0, q} - {1'b0, x});
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] reduce(input mode_e m, input logic [W:0] raw,
                                          input logic [W-1:0] q);
    logic [W-1:0] r;
    if (m == M_SUB) r = raw[W] ? (raw[W-1:0] + q) : raw[W-1:0];
    else            r = (raw >= {1'b0, q}) ? W'(raw - {1'b0, q}) : raw[W-1:0];
    return r;
  endfunction

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [CW-1:0]          coeff_q, coeff_d;
  logic [PW-1:0]          pbase_q, pbase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   s1_valid_q, s1_valid_d;
  logic [LANES*(W+1)-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [CW-1:0]          s1_coeff_q, s1_coeff_d;
  logic [PW-1:0]          s1_pbase_q, s1_pbase_d;
  logic                   s1_last_q, s1_last_d;

  logic                   out_valid_q, out_valid_d;
  logic [LANES*W-1:0]     out_a_q, out_a_d, out_b_q, out_b_d;
  logic [CW-1:0]          out_coeff_q, out_coeff_d;
  logic [PW-1:0]          out_pbase_q, out_pbase_d;
  logic                   out_last_q, out_last_d;

  logic                   stall, accept, in_last;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    coeff_d     = coeff_q;
    pbase_d     = pbase_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_coeff_d  = s1_coeff_q;
    s1_pbase_d  = s1_pbase_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_coeff_d = out_coeff_q;
    out_pbase_d = out_pbase_q;
    out_last_d  = out_last_q;

    stall    = out_valid_q && !out_ready;
    in_ready = (state_q == S_RUN) && !stall;
    accept   = in_valid && in_ready;
    in_last  = (coeff_q == CW'(NCOEFF - 1)) && (pbase_q == PW'(NPRIMES - LANES));

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        mode_d  = mode_e'(mode);
        coeff_d = '0;
        pbase_d = '0;
        busy_d  = 1'b1;
      end
      S_RUN:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if (out_valid_q && out_ready && out_last_q) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      if (32'(pbase_q) + LANES >= NPRIMES) begin
        pbase_d = '0;
        coeff_d = (coeff_q == CW'(NCOEFF - 1)) ? '0 : coeff_q + 1'b1;
      end else begin
        pbase_d = pbase_q + PW'(LANES);
      end
      for (int unsigned k = 0; k < LANES; k++) begin
        s1_a_d[k*(W+1) +: W+1] = raw_op(mode_q, in_a1[k*W +: W], in_a2[k*W +: W],
                                        residue(prime_q, pbase_q, k),
                                        residue(delta, pbase_q, k), 1'b0);
        s1_b_d[k*(W+1) +: W+1] = raw_op(mode_q, in_b1[k*W +: W], in_b2[k*W +: W],
                                        residue(prime_q, pbase_q, k),
                                        residue(delta, pbase_q, k), 1'b1);
      end
      s1_coeff_d = coeff_q;
      s1_pbase_d = pbase_q;
      s1_last_d  = in_last;
    end

    // A stalled output freezes both stages; in_ready is already low then.
    if (!stall) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          out_a_d[k*W +: W] = reduce(mode_q, s1_a_q[k*(W+1) +: W+1],
                                     residue(prime_q, s1_pbase_q, k));
          out_b_d[k*W +: W] = reduce(mode_q, s1_b_q[k*(W+1) +: W+1],
                                     residue(prime_q, s1_pbase_q, k));
        end
        out_coeff_d = s1_coeff_q;
        out_pbase_d = s1_pbase_q;
        out_last_d  = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_ADD;
      coeff_q     <= '0;
      pbase_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_coeff_q  <= '0;
      s1_pbase_q  <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_coeff_q <= '0;
      out_pbase_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      coeff_q     <= coeff_d;
      pbase_q     <= pbase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_coeff_q  <= s1_coeff_d;
      s1_pbase_q  <= s1_pbase_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_coeff_q <= out_coeff_d;
      out_pbase_q <= out_pbase_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_a          = out_a_q;
  assign out_b          = out_b_q;
  assign out_coeff      = out_coeff_q;
  assign out_prime_base = out_pbase_q;
  assign out_last       = out_last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
